// File: rtl/freeplay_voice.sv
// Free-play voice: note keys with octave buttons drive a square-wave buzzer.
// Live mode sounds while a key is held; timed mode plays one-shot notes with retrigger.
module freeplay_voice #(
  parameter int NOTE_KEYS = 7,
  parameter int DIV_BITS = 20,
  parameter logic [NOTE_KEYS*DIV_BITS-1:0] NOTE_DIV = {
    20'd404924, 20'd454545, 20'd510204, 20'd572738,
    20'd606796, 20'd681013, 20'd764526},
  parameter int OCT_BITS = 3,
  parameter int OCT_MIN = 1,
  parameter int OCT_MAX = 7,
  parameter int OCT_RESET = 4,
  parameter int UNIT_CYCLES = 25_000_000,
  parameter int LEN_SEL_BITS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    mode,
  input  logic                    oct_up,
  input  logic                    oct_down,
  input  logic [NOTE_KEYS-1:0]    note_key,
  input  logic [LEN_SEL_BITS-1:0] length_sel,
  output logic [OCT_BITS-1:0]     octave,
  output logic [NOTE_KEYS-1:0]    led,
  output logic                    busy,
  output logic                    buzzer
);

  localparam int IDX_BITS = (NOTE_KEYS > 1) ? $clog2(NOTE_KEYS) : 1;
  localparam longint unsigned LEN_MAX = 64'(UNIT_CYCLES) << ((1 << LEN_SEL_BITS) - 1);
  localparam int TMR_BITS = $clog2(LEN_MAX + 64'd1);

  typedef enum logic [0:0] {IDLE = 1'b0, PLAY = 1'b1} state_t;

  function automatic logic [IDX_BITS-1:0] lowest_idx(input logic [NOTE_KEYS-1:0] v);
    logic [IDX_BITS-1:0] idx;
    idx = '0;
    for (int i = NOTE_KEYS - 1; i >= 0; i--) idx = v[i] ? IDX_BITS'(i) : idx;
    return idx;
  endfunction

  // Half-period of a note at an octave; a divider of 0 would never wrap, so clamp to 1.
  function automatic logic [DIV_BITS-1:0] half_period(input logic [IDX_BITS-1:0] idx,
                                                      input logic [OCT_BITS-1:0] oct);
    logic [DIV_BITS-1:0] hp;
    hp = NOTE_DIV[int'(idx)*DIV_BITS +: DIV_BITS] >> (oct - OCT_BITS'(OCT_MIN));
    return (hp == '0) ? DIV_BITS'(1'b1) : hp;
  endfunction

  function automatic logic [NOTE_KEYS-1:0] onehot(input logic [IDX_BITS-1:0] idx);
    return NOTE_KEYS'(1'b1) << idx;
  endfunction

  state_t                state_r;
  logic [NOTE_KEYS-1:0]  key_s_r, key_d_r;
  logic                  up_s_r, up_d_r, dn_s_r, dn_d_r;
  logic [OCT_BITS-1:0]   octave_r;
  logic                  mode_lat_r;
  logic [IDX_BITS-1:0]   note_r;
  logic [DIV_BITS-1:0]   hp_r, cnt_r;
  logic [TMR_BITS-1:0]   tmr_r;
  logic                  buzzer_r, busy_r;
  logic [NOTE_KEYS-1:0]  led_r;

  logic [NOTE_KEYS-1:0]  key_rise_s;
  logic                  up_rise_s, dn_rise_s, oct_chg_s, cnt_wrap_s;
  logic [OCT_BITS-1:0]   oct_nxt_s;
  logic [IDX_BITS-1:0]   live_idx_s, rise_idx_s;
  logic [DIV_BITS-1:0]   hp_live_s, hp_rise_s, hp_keep_s, cnt_inc_s;
  logic [TMR_BITS-1:0]   tmr_load_s;

  // Edge detection, saturating octave step, note selection and divider helpers
  always_comb begin
    key_rise_s = key_s_r & ~key_d_r;
    up_rise_s  = up_s_r & ~up_d_r;
    dn_rise_s  = dn_s_r & ~dn_d_r;
    if (up_rise_s && !dn_rise_s && (octave_r < OCT_BITS'(OCT_MAX))) begin
      oct_nxt_s = octave_r + OCT_BITS'(1'b1);
    end else if (dn_rise_s && !up_rise_s && (octave_r > OCT_BITS'(OCT_MIN))) begin
      oct_nxt_s = octave_r - OCT_BITS'(1'b1);
    end else begin
      oct_nxt_s = octave_r;
    end
    oct_chg_s  = (oct_nxt_s != octave_r);
    live_idx_s = lowest_idx(key_s_r);
    rise_idx_s = lowest_idx(key_rise_s);
    hp_live_s  = half_period(live_idx_s, oct_nxt_s);
    hp_rise_s  = half_period(rise_idx_s, oct_nxt_s);
    hp_keep_s  = half_period(note_r, oct_nxt_s);
    cnt_wrap_s = (cnt_r == hp_r - DIV_BITS'(1'b1));
    cnt_inc_s  = cnt_wrap_s ? '0 : cnt_r + DIV_BITS'(1'b1);
    tmr_load_s = TMR_BITS'(UNIT_CYCLES) << length_sel;
  end

  // Input sampling, octave register, play FSM, tone divider, timer and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      key_s_r <= '0; key_d_r <= '0;
      up_s_r <= 1'b0; up_d_r <= 1'b0; dn_s_r <= 1'b0; dn_d_r <= 1'b0;
      octave_r <= OCT_BITS'(OCT_RESET);
      mode_lat_r <= 1'b0;
      note_r <= '0; hp_r <= '0; cnt_r <= '0; tmr_r <= '0;
      buzzer_r <= 1'b0; busy_r <= 1'b0; led_r <= '0;
    end else begin
      key_s_r <= note_key; key_d_r <= key_s_r;
      up_s_r <= oct_up; up_d_r <= up_s_r; dn_s_r <= oct_down; dn_d_r <= dn_s_r;
      octave_r <= oct_nxt_s;
      if (!en) begin
        state_r <= IDLE; cnt_r <= '0; tmr_r <= '0;
        buzzer_r <= 1'b0; busy_r <= 1'b0; led_r <= '0;
      end else begin
        case (state_r)
          IDLE: begin
            if (!mode && (key_s_r != '0)) begin
              state_r <= PLAY; mode_lat_r <= 1'b0; note_r <= live_idx_s; hp_r <= hp_live_s;
              cnt_r <= '0; buzzer_r <= 1'b0; busy_r <= 1'b1; led_r <= onehot(live_idx_s);
            end else if (mode && (key_rise_s != '0)) begin
              state_r <= PLAY; mode_lat_r <= 1'b1; note_r <= rise_idx_s; hp_r <= hp_rise_s;
              cnt_r <= '0; tmr_r <= tmr_load_s;
              buzzer_r <= 1'b0; busy_r <= 1'b1; led_r <= onehot(rise_idx_s);
            end else begin
              state_r <= IDLE; cnt_r <= '0; tmr_r <= '0;
              buzzer_r <= 1'b0; busy_r <= 1'b0; led_r <= '0;
            end
          end
          PLAY: begin
            if ((mode != mode_lat_r) || (!mode_lat_r && (key_s_r == '0)) ||
                (mode_lat_r && (key_rise_s == '0) && (tmr_r == TMR_BITS'(1'b1)))) begin
              state_r <= IDLE; cnt_r <= '0; tmr_r <= '0;
              buzzer_r <= 1'b0; busy_r <= 1'b0; led_r <= '0;
            end else if (!mode_lat_r) begin
              if ((live_idx_s != note_r) || oct_chg_s) begin
                note_r <= live_idx_s; hp_r <= hp_live_s; cnt_r <= '0; led_r <= onehot(live_idx_s);
              end else begin
                cnt_r <= cnt_inc_s; buzzer_r <= buzzer_r ^ cnt_wrap_s;
              end
            end else if (key_rise_s != '0) begin
              note_r <= rise_idx_s; hp_r <= hp_rise_s; cnt_r <= '0;
              tmr_r <= tmr_load_s; led_r <= onehot(rise_idx_s);
            end else begin
              // Timed note keeps its pitch class; only the octave can move it.
              tmr_r <= tmr_r - TMR_BITS'(1'b1);
              if (oct_chg_s) begin
                hp_r <= hp_keep_s; cnt_r <= '0;
              end else begin
                cnt_r <= cnt_inc_s; buzzer_r <= buzzer_r ^ cnt_wrap_s;
              end
            end
          end
          default: begin
            state_r <= IDLE; cnt_r <= '0; tmr_r <= '0;
            buzzer_r <= 1'b0; busy_r <= 1'b0; led_r <= '0;
          end
        endcase
      end
    end
  end

  assign octave = octave_r;
  assign led    = led_r;
  assign busy   = busy_r;
  assign buzzer = buzzer_r;

endmodule

// File: doc/freeplay_voice.md
Name: freeplay_voice

Overview:
- Parametrised successor to the single-voice free-play block.
- Takes a bank of note keys, octave up/down buttons and a length selector; drives a square-wave buzzer and one-hot note LEDs.
- Adds a selectable timed mode (one-shot notes of programmable length with retrigger), deterministic key priority, saturating octave range and a busy flag.
- Sits under the mode top level, beside the auto-play and learn modes, sharing clk/rst_n.

Parameters:
NOTE_KEYS, 7, number of note keys / LEDs
DIV_BITS, 20, width of one half-period divider entry
NOTE_DIV, packed NOTE_KEYS*DIV_BITS vector, half-period in clk cycles of each note at octave OCT_MIN (entry i at bits [i*DIV_BITS +: DIV_BITS])
OCT_BITS, 3, octave register width
OCT_MIN, 1, lowest octave
OCT_MAX, 7, highest octave
OCT_RESET, 4, octave after reset
UNIT_CYCLES, 25_000_000, clk cycles per length unit in timed mode
LEN_SEL_BITS, 2, width of length_sel

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  block enable; low forces silence
mode  in  1  0 = live (sound while key held), 1 = timed (one-shot per press)
oct_up  in  1  octave-up button level
oct_down  in  1  octave-down button level
note_key  in  NOTE_KEYS  note key levels, bit i = note i
length_sel  in  LEN_SEL_BITS  timed-mode duration = UNIT_CYCLES << length_sel
octave  out  OCT_BITS  current octave
led  out  NOTE_KEYS  one-hot sounding note, 0 when silent
busy  out  1  high while in PLAY
buzzer  out  1  square-wave tone output

Behaviour:
- Reset (async, rst_n=0): octave=OCT_RESET, state IDLE, led=0, busy=0, buzzer=0, all counters and edge-detect registers 0.
- All inputs are sampled on the posedge of clk and edge-detected with one register stage. A "rise" means the bit is 1 now and was 0 last cycle.
- Octave control:
  - rise of oct_up alone: octave+1, saturating at OCT_MAX.
  - rise of oct_down alone: octave-1, saturating at OCT_MIN.
  - both rise in the same cycle: no change.
  - Octave updates regardless of en and is kept across en low.
- Key priority: the selected note is the lowest set index of note_key.
- Half-period: hp = NOTE_DIV[sel] >> (octave - OCT_MIN). If hp = 0, use 1.
  - Divider counter counts 0..hp-1; at hp-1 it wraps to 0 and toggles buzzer.
  - Latch hp when entering PLAY and on every note/octave change. The counter restarts at 0 on each latch.
- FSM, states IDLE and PLAY:
  - IDLE: buzzer=0, led=0, busy=0.
  - Live mode: IDLE->PLAY when note_key != 0.
    - In PLAY, a change of selected note or octave relatches hp, restarts the counter and keeps the buzzer level.
    - PLAY->IDLE when note_key == 0; buzzer forced 0 in that cycle.
  - Timed mode: IDLE->PLAY on any rise in note_key.
    - Latch the selected note from the rising bits (lowest index) and load the timer with UNIT_CYCLES << length_sel.
    - The timer decrements each cycle. PLAY->IDLE when it reaches 1.
    - A new rise during PLAY retriggers: new note, timer reloaded, counter restarted.
    - Releasing keys does not end the note.
    - Octave change during PLAY relatches hp; the note is kept.
  - mode change while in PLAY: go to IDLE the next cycle.
  - en=0: state forced IDLE next cycle, timer cleared. Edge detectors keep running, so a key already held when en rises does not count as a rise in timed mode; live mode starts playing.
- Latency: key sampled at edge N -> led/busy valid after edge N+1 -> first buzzer toggle hp cycles later.
- led = one-hot of the latched note when in PLAY, else 0.

Test Plan:
- Setup for all scenarios: NOTE_KEYS=7, NOTE_DIV entry0=64, entry1=48, UNIT_CYCLES=100, OCT_MIN=1, OCT_MAX=7, OCT_RESET=4.
- Reset: rst_n low mid-tone -> buzzer=0, led=0, busy=0, octave=4 immediately, without waiting for a clock edge.
- Live mode: hold note_key=7'b0000001 -> led=0000001, buzzer period 2*(64>>3)=16 cycles. Add bit1 -> still note0. Release bit0 -> note1, hp=6, counter restarts. Release all -> IDLE next cycle, buzzer=0.
- Octave saturation: 5 oct_up pulses -> octave 5,6,7,7,7. oct_up and oct_down rising in the same cycle -> unchanged. 8 oct_down pulses -> octave ends at 1.
- Timed mode: length_sel=2, press and release note0 -> busy high for exactly 400 cycles. Re-press at cycle 200 -> busy lasts 400 cycles from the re-press.
- en gating: en=0 during PLAY -> IDLE next cycle, octave kept. en=1 with key held in timed mode -> stays IDLE until release and re-press.
- Small-divider clamp: NOTE_DIV entry=4 at octave 7 -> hp clamps to 1, buzzer toggles every cycle.
